// File: rtl/dtr_reader.sv
`default_nettype none
// ============================================================================
//  Module   : dtr_reader
//  Purpose  : Controller and reader for the on-die digital temperature
//             readout (DTR) primitive. Pulses STARTPULSE, waits for the DTR
//             valid bit, captures the 6-bit temperature code and reports it
//             with a valid pulse, a timeout pulse and a threshold alarm.
//             Conversions start on request or from an internal period timer.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1  system clock
//    rst_n         in   1  asynchronous active-low reset
//    req_i         in   1  conversion request
//    thresh_i      in   6  alarm threshold code
//    dtr_out_i     in   8  DTROUT7..0 (asynchronous to clk)
//    dtr_start_o   out  1  DTR STARTPULSE
//    busy_o        out  1  high whenever not IDLE
//    temp_o        out  6  last captured temperature code
//    temp_valid_o  out  1  one-cycle pulse when temp_o updates
//    have_sample_o out  1  sticky, set on first capture
//    timeout_o     out  1  one-cycle pulse on conversion abort
//    alarm_o       out  1  have_sample_o & (temp_o >= thresh_i), registered
// ============================================================================
module dtr_reader #(
   parameter int START_WIDTH    = 16,
   parameter int SETTLE_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 16384,
   parameter int PERIOD         = 0,
   parameter int CNT_W          = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_i,
   input  logic [5:0] thresh_i,
   input  logic [7:0] dtr_out_i,
   output logic       dtr_start_o,
   output logic       busy_o,
   output logic [5:0] temp_o,
   output logic       temp_valid_o,
   output logic       have_sample_o,
   output logic       timeout_o,
   output logic       alarm_o
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] START  = 2'd1;
   localparam logic [1:0] SETTLE = 2'd2;
   localparam logic [1:0] WAIT   = 2'd3;

   localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_WIDTH - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             pending;
   logic             period_hit;
   logic             launch;
   logic             capture;

   // Bit 6 of each synchroniser word is DTROUT7 (valid); bits 5:0 the code.
   // DTROUT6 carries no information for this reader and is not synchronised.
   logic [6:0]       sync_meta;
   logic [6:0]       sync;
   logic [6:0]       prev;
   logic             unused_dtr_bit6;

   assign unused_dtr_bit6 = dtr_out_i[6];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= '0;
         sync      <= '0;
         prev      <= '0;
      end else begin
         sync_meta <= {dtr_out_i[7], dtr_out_i[5:0]};
         sync      <= sync_meta;
         prev      <= sync;
      end
   end

   // Free-running auto-trigger timer, only present when PERIOD is non-zero.
   generate
      if (PERIOD > 0) begin : g_period
         localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);
         logic [CNT_W-1:0] period_cnt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               period_cnt <= '0;
            end else if (period_cnt == PERIOD_LAST) begin
               period_cnt <= '0;
            end else begin
               period_cnt <= period_cnt + 1'b1;
            end
         end

         assign period_hit = (period_cnt == PERIOD_LAST);
      end else begin : g_no_period
         assign period_hit = 1'b0;
      end
   endgenerate

   // A trigger seen in IDLE launches directly; otherwise it is held in the
   // one-deep pending flag and launches on the first cycle back in IDLE.
   assign launch  = (state == IDLE) && (pending || req_i || period_hit);

   // Two consecutive identical valid samples guard against catching the
   // code while its bits are still changing.
   assign capture = sync[6] && prev[6] && (sync[5:0] == prev[5:0]);

   assign dtr_start_o = (state == START);
   assign busy_o      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         pending       <= 1'b0;
         temp_o        <= '0;
         temp_valid_o  <= 1'b0;
         have_sample_o <= 1'b0;
         timeout_o     <= 1'b0;
         alarm_o       <= 1'b0;
      end else begin
         temp_valid_o <= 1'b0;
         timeout_o    <= 1'b0;
         alarm_o      <= have_sample_o && (temp_o >= thresh_i);
         pending      <= launch ? 1'b0 : (pending || req_i || period_hit);

         case (state)
            IDLE: begin
               if (launch) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == START_LAST) begin
                  state <= SETTLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  state <= WAIT;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT: begin
               // Capture takes priority over a coincident timeout.
               if (capture) begin
                  temp_o        <= sync[5:0];
                  temp_valid_o  <= 1'b1;
                  have_sample_o <= 1'b1;
                  state         <= IDLE;
               end else if (cnt == TIMEOUT_LAST) begin
                  timeout_o <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
